cycle_sequencer: RTL and testbench

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

---
 rtl/cycle_sequencer.sv | 168 ++++++++++++++++
 tb/tb_cycle_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
// -----------------------------------------------------------------------------
// cycle_sequencer
//
// Instruction phase sequencer for a simple multi-cycle CPU. It walks each
// instruction through FETCH -> DECODE -> (STALL)* -> EXEC and supports
// halting at instruction boundaries, single-stepping from HALT, and a bounded
// stall that forces EXEC after STALL_LIMIT consecutive stall cycles.
//
// Parameters
//   START_RUN        1 = come out of reset in FETCH, 0 = come out in HALT
//   STALL_LIMIT      max consecutive STALL cycles before a forced EXEC (1..255)
//   INSTR_COUNT_INIT reset value of instr_count (0 for normal use; a non-zero
//                    preset lets the counter wrap be reached quickly)
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous, active-high; overrides every other input
//   run         level; in HALT, 1 resumes continuous execution
//   step        pulse; in HALT, executes exactly one instruction
//   halt_req    pulse; requests HALT at the next instruction boundary
//   stall       level; datapath busy, holds off EXEC
//   cycle       one-hot phase: [0] FETCH, [1] DECODE, [2] EXEC (000 otherwise)
//   halted      high while in HALT
//   stall_err   sticky flag, set when a stall is cut short by STALL_LIMIT
//   instr_count number of completed EXEC cycles, wraps FFFF -> 0000
// -----------------------------------------------------------------------------
module cycle_sequencer #(
  parameter bit          START_RUN        = 1'b1,
  parameter int unsigned STALL_LIMIT      = 15,
  parameter logic [15:0] INSTR_COUNT_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        halt_req,
  input  logic        stall,
  output logic [2:0]  cycle,
  output logic        halted,
  output logic        stall_err,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_STALL  = 3'd3,
    S_EXEC   = 3'd4
  } state_t;

  localparam state_t     RESET_STATE = START_RUN ? S_FETCH : S_HALT;
  // The counter holds (STALL cycles so far - 1); reaching LIMIT_M1 means the
  // current STALL cycle is the STALL_LIMIT-th one.
  localparam logic [7:0] LIMIT_M1    = 8'(STALL_LIMIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;
  logic        pending_q, pending_d;     // latched halt_req
  logic        step_mode_q, step_mode_d; // current instruction was started by step
  logic        stall_err_q, stall_err_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic [2:0]  cycle_q;
  logic        halted_q;

  function automatic logic [2:0] cycle_of(input state_t s);
    case (s)
      S_FETCH:  cycle_of = 3'b001;
      S_DECODE: cycle_of = 3'b010;
      S_EXEC:   cycle_of = 3'b100;
      default:  cycle_of = 3'b000;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    stall_cnt_d   = stall_cnt_q;
    pending_d     = pending_q;
    step_mode_d   = step_mode_q;
    stall_err_d   = stall_err_q;
    instr_count_d = instr_count_q;

    case (state_q)
      S_HALT: begin
        // halt_req is ignored here; run wins over step.
        if (run) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b0;
        end else if (step) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b1;
        end
      end

      S_FETCH: begin
        pending_d = pending_q | halt_req;
        state_d   = S_DECODE;
      end

      S_DECODE: begin
        pending_d = pending_q | halt_req;
        if (stall) begin
          state_d     = S_STALL;
          stall_cnt_d = 8'd0;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_STALL: begin
        pending_d = pending_q | halt_req;
        if (!stall) begin
          state_d = S_EXEC;
        end else if (stall_cnt_q == LIMIT_M1) begin
          state_d     = S_EXEC;
          stall_err_d = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt_q + 8'd1;
        end
      end

      S_EXEC: begin
        // The instruction always completes here, so halting never cuts one short.
        instr_count_d = instr_count_q + 16'd1;
        if (pending_q || halt_req || step_mode_q) begin
          state_d   = S_HALT;
          pending_d = 1'b0;
        end else begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // Outputs are registered from the next state so they depend on the state
  // register only, never on the inputs directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RESET_STATE;
      stall_cnt_q   <= 8'd0;
      pending_q     <= 1'b0;
      step_mode_q   <= 1'b0;
      stall_err_q   <= 1'b0;
      instr_count_q <= INSTR_COUNT_INIT;
      cycle_q       <= cycle_of(RESET_STATE);
      halted_q      <= (RESET_STATE == S_HALT);
    end else begin
      state_q       <= state_d;
      stall_cnt_q   <= stall_cnt_d;
      pending_q     <= pending_d;
      step_mode_q   <= step_mode_d;
      stall_err_q   <= stall_err_d;
      instr_count_q <= instr_count_d;
      cycle_q       <= cycle_of(state_d);
      halted_q      <= (state_d == S_HALT);
    end
  end

  assign cycle       = cycle_q;
  assign halted      = halted_q;
  assign stall_err   = stall_err_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cycle_sequencer
//
// Scoreboard bench for cycle_sequencer. Each driven cycle pushes the expected
// outputs into exp_q; the outputs seen 1 time unit after the clock edge are
// pushed into obs_q; each scenario task then drains both queues and compares.
// dut_a uses default parameters; dut_b starts in HALT with instr_count preset
// near FFFF so the counter wrap is reached in a few instructions.
// -----------------------------------------------------------------------------
module tb_cycle_sequencer;

  typedef struct packed {
    logic [2:0]  cyc;
    logic        hlt;
    logic        err;
    logic [15:0] cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset_a = 1'b1;
  logic        reset_b = 1'b1;
  logic        run = 1'b0, step = 1'b0, halt_req = 1'b0, stall = 1'b0;
  logic [2:0]  cycle_a, cycle_b;
  logic        halted_a, halted_b, err_a, err_b;
  logic [15:0] count_a, count_b;

  logic        dut_sel = 1'b0;
  obs_t        exp_q[$];
  obs_t        obs_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  cycle_sequencer dut_a (
    .clk(clk), .reset(reset_a), .run(run), .step(step), .halt_req(halt_req),
    .stall(stall), .cycle(cycle_a), .halted(halted_a), .stall_err(err_a),
    .instr_count(count_a)
  );

  cycle_sequencer #(.START_RUN(1'b0), .STALL_LIMIT(15), .INSTR_COUNT_INIT(16'hFFFE)) dut_b (
    .clk(clk), .reset(reset_b), .run(run), .step(step), .halt_req(halt_req),
    .stall(stall), .cycle(cycle_b), .halted(halted_b), .stall_err(err_b),
    .instr_count(count_b)
  );

  task automatic capture();
    if (dut_sel) obs_q.push_back('{cycle_b, halted_b, err_b, count_b});
    else         obs_q.push_back('{cycle_a, halted_a, err_a, count_a});
  endtask

  // Drive one clock cycle of inputs, record what the DUT must show after it.
  task automatic drv(input logic r, input logic s, input logic h, input logic st,
                     input logic [2:0] ec, input logic eh, input logic [15:0] en,
                     input logic ee);
    run = r; step = s; halt_req = h; stall = st;
    exp_q.push_back('{ec, eh, ee, en});
    @(posedge clk); #1;
    capture();
    step = 1'b0; halt_req = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, o;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('{3'b001, 1'b0, 1'b0, 16'h0000});
    capture();
    reset_a = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset: got cycle=%b halted=%b err=%b count=%h, want cycle=%b halted=%b err=%b count=%h",
                 o.cyc, o.hlt, o.err, o.cnt, e.cyc, e.hlt, e.err, e.cnt);
      end else $display("check reset: cycle=%b halted=%b err=%b count=%h", o.cyc, o.hlt, o.err, o.cnt);
    end
  endtask

  task automatic test_basic();
    obs_t e, o;
    int i = 0;
    drv(0,0,0,0, 3'b010,0,16'd0,0); drv(0,0,0,0, 3'b100,0,16'd0,0); drv(0,0,0,0, 3'b001,0,16'd1,0);
    drv(0,0,0,0, 3'b010,0,16'd1,0); drv(0,0,0,0, 3'b100,0,16'd1,0); drv(0,0,0,0, 3'b001,0,16'd2,0);
    drv(0,0,0,0, 3'b010,0,16'd2,0); drv(0,0,0,0, 3'b100,0,16'd2,0); drv(0,0,0,0, 3'b001,0,16'd3,0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL basic[%0d]: got cycle=%b halted=%b err=%b count=%h, want cycle=%b halted=%b err=%b count=%h",
                 i, o.cyc, o.hlt, o.err, o.cnt, e.cyc, e.hlt, e.err, e.cnt);
      end else $display("check basic[%0d]: cycle=%b count=%h", i, o.cyc, o.cnt);
      i++;
    end
  endtask

  task automatic test_stall();
    obs_t e, o;
    int i = 0;
    drv(0,0,0,0, 3'b010,0,16'd3,0);
    repeat (4) drv(0,0,0,1, 3'b000,0,16'd3,0);
    drv(0,0,0,0, 3'b100,0,16'd3,0);
    drv(0,0,0,0, 3'b001,0,16'd4,0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL stall[%0d]: got cycle=%b halted=%b err=%b count=%h, want cycle=%b halted=%b err=%b count=%h",
                 i, o.cyc, o.hlt, o.err, o.cnt, e.cyc, e.hlt, e.err, e.cnt);
      end else $display("check stall[%0d]: cycle=%b err=%b count=%h", i, o.cyc, o.err, o.cnt);
      i++;
    end
  endtask

  task automatic test_stall_limit();
    obs_t e, o;
    int i = 0;
    drv(0,0,0,0, 3'b010,0,16'd4,0);
    repeat (15) drv(0,0,0,1, 3'b000,0,16'd4,0);
    drv(0,0,0,1, 3'b100,0,16'd4,1);
    drv(0,0,0,1, 3'b001,0,16'd5,1);
    drv(0,0,0,0, 3'b010,0,16'd5,1);
    drv(0,0,0,0, 3'b100,0,16'd5,1);
    drv(0,0,0,0, 3'b001,0,16'd6,1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL stall_limit[%0d]: got cycle=%b halted=%b err=%b count=%h, want cycle=%b halted=%b err=%b count=%h",
                 i, o.cyc, o.hlt, o.err, o.cnt, e.cyc, e.hlt, e.err, e.cnt);
      end else $display("check stall_limit[%0d]: cycle=%b err=%b count=%h", i, o.cyc, o.err, o.cnt);
      i++;
    end
  endtask

  task automatic test_halt();
    obs_t e, o;
    int i = 0;
    drv(0,0,1,0, 3'b010,0,16'd6,1);
    drv(0,0,0,0, 3'b100,0,16'd6,1);
    drv(0,0,0,0, 3'b000,1,16'd7,1);
    repeat (5) drv(0,0,0,0, 3'b000,1,16'd7,1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL halt[%0d]: got cycle=%b halted=%b err=%b count=%h, want cycle=%b halted=%b err=%b count=%h",
                 i, o.cyc, o.hlt, o.err, o.cnt, e.cyc, e.hlt, e.err, e.cnt);
      end else $display("check halt[%0d]: cycle=%b halted=%b count=%h", i, o.cyc, o.hlt, o.cnt);
      i++;
    end
  endtask

  task automatic test_step();
    obs_t e, o;
    int i = 0;
    drv(0,0,1,0, 3'b000,1,16'd7,1);   // halt_req in HALT is ignored
    drv(0,1,0,0, 3'b001,0,16'd7,1);   // single step
    drv(0,0,0,0, 3'b010,0,16'd7,1);
    drv(0,0,0,0, 3'b100,0,16'd7,1);
    drv(0,0,0,0, 3'b000,1,16'd8,1);
    drv(1,1,0,0, 3'b001,0,16'd8,1);   // run + step: run wins
    drv(0,0,0,0, 3'b010,0,16'd8,1);
    drv(0,0,0,0, 3'b100,0,16'd8,1);
    drv(0,0,0,0, 3'b001,0,16'd9,1);
    drv(0,1,0,0, 3'b010,0,16'd9,1);   // step outside HALT is ignored
    drv(0,0,0,0, 3'b100,0,16'd9,1);
    drv(0,0,0,0, 3'b001,0,16'd10,1);
    drv(0,0,0,0, 3'b010,0,16'd10,1);
    drv(0,0,0,0, 3'b100,0,16'd10,1);
    drv(0,0,1,0, 3'b000,1,16'd11,1);  // halt_req during EXEC
    drv(1,0,0,0, 3'b001,0,16'd11,1);
    drv(0,0,0,0, 3'b010,0,16'd11,1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL step[%0d]: got cycle=%b halted=%b err=%b count=%h, want cycle=%b halted=%b err=%b count=%h",
                 i, o.cyc, o.hlt, o.err, o.cnt, e.cyc, e.hlt, e.err, e.cnt);
      end else $display("check step[%0d]: cycle=%b halted=%b count=%h", i, o.cyc, o.hlt, o.cnt);
      i++;
    end
  endtask

  task automatic test_reset_mid_stall();
    obs_t e, o;
    int i = 0;
    drv(0,0,0,1, 3'b000,0,16'd11,1);
    drv(0,0,0,1, 3'b000,0,16'd11,1);
    #3 reset_a = 1'b1;                 // mid-cycle, no clock edge
    #1;
    exp_q.push_back('{3'b001, 1'b0, 1'b0, 16'h0000});
    capture();
    @(posedge clk); #1;
    exp_q.push_back('{3'b001, 1'b0, 1'b0, 16'h0000});
    capture();
    reset_a = 1'b0;
    drv(0,0,0,0, 3'b010,0,16'd0,0);
    drv(0,0,0,0, 3'b100,0,16'd0,0);
    drv(0,0,0,0, 3'b001,0,16'd1,0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid_stall[%0d]: got cycle=%b halted=%b err=%b count=%h, want cycle=%b halted=%b err=%b count=%h",
                 i, o.cyc, o.hlt, o.err, o.cnt, e.cyc, e.hlt, e.err, e.cnt);
      end else $display("check reset_mid_stall[%0d]: cycle=%b err=%b count=%h", i, o.cyc, o.err, o.cnt);
      i++;
    end
  endtask

  task automatic test_wrap();
    obs_t e, o;
    int i = 0;
    dut_sel = 1'b1;
    exp_q.push_back('{3'b000, 1'b1, 1'b0, 16'hFFFE});
    capture();
    @(posedge clk); #1;
    reset_b = 1'b0;
    drv(0,0,0,0, 3'b000,1,16'hFFFE,0);
    drv(1,0,0,0, 3'b001,0,16'hFFFE,0);
    drv(1,0,0,0, 3'b010,0,16'hFFFE,0);
    drv(0,0,0,0, 3'b100,0,16'hFFFE,0);
    drv(0,0,0,0, 3'b001,0,16'hFFFF,0);
    drv(0,0,0,0, 3'b010,0,16'hFFFF,0);
    drv(0,0,0,0, 3'b100,0,16'hFFFF,0);
    drv(0,0,0,0, 3'b001,0,16'h0000,0);
    drv(0,0,0,0, 3'b010,0,16'h0000,0);
    drv(0,0,0,0, 3'b100,0,16'h0000,0);
    drv(0,0,0,0, 3'b001,0,16'h0001,0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got cycle=%b halted=%b err=%b count=%h, want cycle=%b halted=%b err=%b count=%h",
                 i, o.cyc, o.hlt, o.err, o.cnt, e.cyc, e.hlt, e.err, e.cnt);
      end else $display("check wrap[%0d]: cycle=%b halted=%b count=%h", i, o.cyc, o.hlt, o.cnt);
      i++;
    end
    dut_sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_stall_limit();
    test_halt();
    test_step();
    test_reset_mid_stall();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no end, want end of test");
    $fatal(1, "watchdog");
  end

endmodule
